// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instr}; clear dominates push and pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only visible once count says so.
    always_ff @(posedge CLK) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues one outstanding imem request at a time,
// buffers returned words and hands them to decode under a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    DEPTH    = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    output logic         imem_ren,
    output word_t        imem_addr,
    input  logic         imem_ready,
    input  word_t        imem_rdata,
    output word_t        instr,
    output word_t        pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         redirect,
    input  word_t        redirect_pc,
    input  logic         halt,
    output logic         halted,
    output fetch_state_t dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

    // Handshakes: a request is live while imem_ren=1 and completes on the cycle
    // imem_ready=1; imem_ren/imem_addr never change while live. Decode takes the
    // head on any cycle with instr_valid && instr_ready.

    fetch_state_t  state;
    word_t         fetch_pc;
    fetch_entry_t  head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          fire;
    logic          hold;
    logic          push;
    logic          pop;
    logic          clear;
    word_t         seq_pc;

    assign fire   = imem_ren && imem_ready;
    assign hold   = imem_ren && !imem_ready;
    assign pop    = instr_valid && instr_ready;
    assign clear  = (state != HALT) && (halt || redirect);
    assign push   = (state == FETCH) && fire && !halt && !redirect && !full;
    assign seq_pc = imem_addr + 32'd4;

    // Occupancy after this edge decides whether the next request may issue.
    assign count_after = clear ? '0 : (count + CW'(push) - CW'(pop));

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (push),
        .push_data ('{pc: imem_addr, instr: imem_rdata}),
        .pop       (pop),
        .clear     (clear),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            imem_ren  <= 1'b0;
            imem_addr <= RESET_PC;
            halted    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (halt) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        imem_ren <= hold;
                    end else if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (hold) begin
                            state <= DROP;
                        end else begin
                            imem_ren  <= 1'b1;
                            imem_addr <= redirect_pc;
                        end
                    end else if (!hold) begin
                        if (fire) fetch_pc <= seq_pc;
                        imem_ren  <= (count_after < CW'(DEPTH));
                        imem_addr <= fire ? seq_pc : fetch_pc;
                    end
                end
                // fetch_pc already holds the redirect target; imem_addr keeps the stale request.
                DROP: begin
                    if (halt) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        imem_ren <= hold;
                    end else begin
                        if (redirect) fetch_pc <= redirect_pc;
                        if (fire) begin
                            state     <= FETCH;
                            imem_ren  <= 1'b1;
                            imem_addr <= redirect ? redirect_pc : fetch_pc;
                        end
                    end
                end
                HALT: begin
                    imem_ren <= hold;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign instr_valid = !empty;
    assign instr       = instr_valid ? head.instr : '0;
    assign pc          = instr_valid ? head.pc : '0;
    assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scripted vector table, hand-built corner sequences and a
// randomized run checked against a stream-level model of the expected instruction order.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         imem_ren;
  word_t        imem_addr;
  logic         imem_ready = 1'b0;
  word_t        imem_rdata;
  word_t        instr;
  word_t        pc;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic         redirect = 1'b0;
  word_t        redirect_pc = '0;
  logic         halt = 1'b0;
  logic         halted;
  fetch_state_t dbg_state;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    logic        rdy;
    logic        ird;
    logic        rd;
    logic [31:0] rpc;
    logic        hl;
    logic        ren;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] hpc;
    logic        hltd;
  } vec_t;

  vec_t tbl[19];

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // Memory model: every word is its own address scrambled by a fixed key.
  assign imem_rdata = imem_addr ^ KEY;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .imem_ren    (imem_ren),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rdy, input logic ird, input logic rd,
                        input logic [31:0] rpc, input logic hl);
    imem_ready  = rdy;
    instr_ready = ird;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 32'h0, 0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst ren", 32'(imem_ren), 32'd0);
    check("rst addr", imem_addr, 32'h0);
    check("rst valid", 32'(instr_valid), 32'd0);
    check("rst instr", instr, 32'h0);
    check("rst pc", pc, 32'h0);
    check("rst halted", 32'(halted), 32'd0);
    nRST = 1'b1;
  endtask

  // ---------------- scoreboard state for the random run ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          pops;
  logic        prev_hold;
  logic [31:0] prev_addr;

  initial begin
    // rdy ird rd rpc hl | ren addr vld hpc hltd
    tbl[0]  = '{1, 1, 0, 32'h0,   0, 1, 32'h0,   0, 32'h0,   0};
    tbl[1]  = '{1, 1, 0, 32'h0,   0, 1, 32'h4,   1, 32'h0,   0};
    tbl[2]  = '{1, 0, 0, 32'h0,   0, 1, 32'h8,   1, 32'h4,   0};
    tbl[3]  = '{1, 0, 0, 32'h0,   0, 0, 32'hC,   1, 32'h4,   0};
    tbl[4]  = '{1, 1, 0, 32'h0,   0, 0, 32'hC,   1, 32'h4,   0};
    tbl[5]  = '{0, 1, 0, 32'h0,   0, 1, 32'hC,   1, 32'h8,   0};
    tbl[6]  = '{0, 1, 0, 32'h0,   0, 1, 32'hC,   0, 32'h0,   0};
    tbl[7]  = '{0, 1, 1, 32'h100, 0, 1, 32'hC,   0, 32'h0,   0};
    tbl[8]  = '{0, 1, 0, 32'h0,   0, 1, 32'hC,   0, 32'h0,   0};
    tbl[9]  = '{1, 1, 0, 32'h0,   0, 1, 32'hC,   0, 32'h0,   0};
    tbl[10] = '{1, 0, 0, 32'h0,   0, 1, 32'h100, 0, 32'h0,   0};
    tbl[11] = '{1, 1, 1, 32'h200, 0, 1, 32'h104, 1, 32'h100, 0};
    tbl[12] = '{0, 1, 0, 32'h0,   0, 1, 32'h200, 0, 32'h0,   0};
    tbl[13] = '{0, 1, 1, 32'h300, 1, 1, 32'h200, 0, 32'h0,   0};
    tbl[14] = '{0, 1, 0, 32'h0,   0, 1, 32'h200, 0, 32'h0,   1};
    tbl[15] = '{1, 1, 0, 32'h0,   0, 1, 32'h200, 0, 32'h0,   1};
    tbl[16] = '{1, 1, 0, 32'h0,   0, 0, 32'h200, 0, 32'h0,   1};
    tbl[17] = '{1, 1, 1, 32'h400, 0, 0, 32'h200, 0, 32'h0,   1};
    tbl[18] = '{0, 0, 0, 32'h0,   0, 0, 32'h200, 0, 32'h0,   1};

    // ---- table-driven scripted run ----
    do_reset();
    for (int i = 0; i < 19; i++) begin
      next_cycle();
      set_in(tbl[i].rdy, tbl[i].ird, tbl[i].rd, tbl[i].rpc, tbl[i].hl);
      @(negedge CLK);
      check($sformatf("r%0d ren", i), 32'(imem_ren), 32'(tbl[i].ren));
      check($sformatf("r%0d addr", i), imem_addr, tbl[i].addr);
      check($sformatf("r%0d valid", i), 32'(instr_valid), 32'(tbl[i].vld));
      check($sformatf("r%0d pc", i), pc, tbl[i].hpc);
      check($sformatf("r%0d instr", i), instr, tbl[i].vld ? (tbl[i].hpc ^ KEY) : 32'h0);
      check($sformatf("r%0d halted", i), 32'(halted), 32'(tbl[i].hltd));
    end

    // ---- nRST pulse clears sticky halted, fetch restarts at RESET_PC ----
    next_cycle();
    set_in(0, 0, 0, 32'h0, 0);
    nRST = 1'b0;
    #2;
    check("pulse halted", 32'(halted), 32'd0);
    check("pulse ren", 32'(imem_ren), 32'd0);
    check("pulse addr", imem_addr, 32'h0);
    next_cycle();
    nRST = 1'b1;
    next_cycle();
    @(negedge CLK);
    check("restart ren", 32'(imem_ren), 32'd1);
    check("restart addr", imem_addr, 32'h0);
    check("restart halted", 32'(halted), 32'd0);

    // ---- reset while that request is still pending ----
    #1;
    nRST = 1'b0;
    #1;
    check("midreq ren", 32'(imem_ren), 32'd0);
    check("midreq addr", imem_addr, 32'h0);
    next_cycle();
    nRST = 1'b1;

    // ---- PC wraps past the top of the address space ----
    next_cycle();
    set_in(1, 1, 1, 32'hFFFF_FFFC, 0);
    @(negedge CLK);
    check("wrap ren0", 32'(imem_ren), 32'd1);
    check("wrap addr0", imem_addr, 32'h0);
    next_cycle();
    set_in(1, 1, 0, 32'h0, 0);
    @(negedge CLK);
    check("wrap addr1", imem_addr, 32'hFFFF_FFFC);
    check("wrap valid1", 32'(instr_valid), 32'd0);
    next_cycle();
    @(negedge CLK);
    check("wrap addr2", imem_addr, 32'h0);
    check("wrap pc2", pc, 32'hFFFF_FFFC);
    check("wrap instr2", instr, 32'hFFFF_FFFC ^ KEY);
    next_cycle();
    @(negedge CLK);
    check("wrap pc3", pc, 32'h0);
    check("wrap addr3", imem_addr, 32'h4);

    // ---- randomized run against the instruction-stream model ----
    do_reset();
    exp_pc    = 32'h0;
    pops      = 0;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt;
      next_cycle();
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 16'hFFFF), 2'b00} << 12;
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0, tgt, 0);
      @(negedge CLK);
      if (prev_hold) begin
        check("rnd hold ren", 32'(imem_ren), 32'd1);
        check("rnd hold addr", imem_addr, prev_addr);
      end
      if (!instr_valid) begin
        check("rnd idle instr", instr, 32'h0);
        check("rnd idle pc", pc, 32'h0);
      end else if (instr_ready) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
        begin
          logic [31:0] want;
          want = exp_q.pop_front();
          check("rnd head pc", pc, want);
          check("rnd head instr", instr, want ^ KEY);
        end
        pops++;
      end
      if (redirect) exp_pc = redirect_pc;
      prev_hold = imem_ren && !imem_ready;
      prev_addr = imem_addr;
    end
    check("rnd progress", 32'(pops >= 200), 32'd1);
    check("rnd never halted", 32'(halted), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
